ready_valid_elastic_buf: RTL and testbench
==========================================

Name: ready_valid_elastic_buf

Overview:
Parametrised ready/valid elastic buffer, the successor to the single-stage ready/valid proxy. It is a circular FIFO of configurable width and depth placed between an upstream producer and a downstream consumer. No combinational path exists from down_ready to up_ready. It adds an occupancy count, an almost-full flag and a synchronous flush.

Parameters:
DATA_W, 8, payload width in bits
DEPTH, 4, number of storage entries; power of two, >= 2
AFULL_THRESH, 3, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH
CNT_W, $clog2(DEPTH+1), width of count (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
up_data  input  DATA_W  upstream payload
up_valid  input  1  upstream payload valid
up_ready  output  1  buffer can accept a word
down_data  output  DATA_W  downstream payload
down_valid  output  1  downstream payload valid
down_ready  input  1  downstream accepts word
flush  input  1  synchronous discard of all stored words
count  output  CNT_W  number of words held
almost_full  output  1  count >= AFULL_THRESH

Behaviour:
- Reset (rst=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Storage cleared to 0.
  - While rst is high: up_ready=0, down_valid=0, down_data=0, almost_full=0.
  - rst has priority over flush and over any handshake in the same cycle.
- Handshake definitions:
  - push = up_valid & up_ready.
  - pop = down_valid & down_ready.
  - A transfer completes only at a rising edge where the respective AND is 1.
- up_ready = !rst & !flush & (count != DEPTH). It is a function of registered state plus rst/flush only, never of down_ready.
  - When full, a pop in the same cycle does NOT open up_ready. Full-and-popping accepts nothing that cycle.
- down_valid = (count != 0).
- down_data = mem[rd_ptr]. When empty it shows the last-written entry at rd_ptr; the bench must not check it while down_valid=0.
- Latency:
  - A word pushed at edge N is visible on down_data/down_valid after edge N. Minimum residency is one cycle.
  - There is no same-cycle bypass.
- Throughput:
  - Simultaneous push and pop sustains 1 word/cycle whenever 0 < count < DEPTH.
  - With DEPTH >= 2, a continuous stream with down_ready=1 never stalls after the first word.
- Stability:
  - While down_valid=1 and down_ready=0, down_data and down_valid are held unchanged.
  - Upstream obligations (up_valid/up_data held until accepted) are not enforced by the block.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - push writes mem[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
- count update per edge:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
  - count never exceeds DEPTH and never underflows; the gating above makes both impossible.
- almost_full is registered-consistent: it is derived from the current count, with no extra cycle of lag.
- Flush:
  - flush=1 at an edge sets wr_ptr=rd_ptr=0 and count=0. Storage contents are not cleared.
  - up_ready=0 during flush, so no push occurs.
  - down_valid still reflects the pre-flush count that cycle. A pop coinciding with flush is legal, and that word counts as delivered.
  - After the flush edge: down_valid=0, count=0, and up_ready=1 if flush has dropped.
- Reset mid-operation: all stored words are discarded. The first push after rst falls is the first word delivered.
- Ordering: strict FIFO; no reordering, duplication or loss except by flush or rst.

Test Plan:
1. Reset with DEPTH=4, DATA_W=8. Hold rst for 2 cycles, then release, with up_valid=1 and down_ready=1 streaming data 0..199 → outputs 0 while rst is high; up_ready=1 the first cycle after release; down stream is exactly 0..199 in order; after the first word, one word per cycle with no bubble.
2. Fill/full: down_ready=0, push 5 words (0x10..0x14) → first 4 accepted; count steps 1,2,3,4; almost_full rises when count=3; up_ready=0 at count=4; 0x14 held upstream. Then down_ready=1 for 1 cycle → 0x10 popped and 0x14 not accepted that cycle; 0x14 accepted on the next edge.
3. Random stalls: up_valid toggled every cycle, down_ready toggled every 3 cycles, 200 words → in-order delivery with a scoreboard; down_data stable while stalled; count always equals scoreboard depth and lies in 0..4.
4. Wrap-around, DEPTH=2: 1000 words with alternating 2-cycle down_ready bursts → pointers wrap more than 400 times; no loss or duplication.
5. Flush with count=3 (words 0xA0..0xA2) and down_ready=1 → 0xA0 delivered on the flush edge; count=0 next cycle; 0xA1 and 0xA2 never appear; a subsequent push of 0xB0 is delivered next.
6. Mid-stream reset: rst asserted for 1 cycle with count=2 → count=0 and down_valid=0 after the edge; next pushed word 0x55 is the next delivered.

Source files
------------

// File: rtl/ready_valid_elastic_buf.sv
// ready_valid_elastic_buf: circular ready/valid FIFO with count, almost-full and flush.
module ready_valid_elastic_buf #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [DATA_W-1:0] down_data,
    output logic              down_valid,
    input  logic              down_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop, clr;

    // up_ready looks only at registered count, so down_ready never reaches it
    always_comb begin
        up_ready    = !rst && !flush && (count_q != CNT_W'(DEPTH));
        down_valid  = !rst && (count_q != '0);
        down_data   = rst ? '0 : mem_q[rd_ptr_q];
        almost_full = !rst && (count_q >= CNT_W'(AFULL_THRESH));
        count       = count_q;
        push        = up_valid && up_ready;
        pop         = down_valid && down_ready;
        clr         = rst || flush;
    end

    always_comb begin
        wr_ptr_d = clr ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d = clr ? '0 : rd_ptr_q + PTR_W'(pop);
        count_d  = clr ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = rst ? '0 : (push && wr_ptr_q == PTR_W'(i)) ? up_data : mem_q[i];
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        mem_q    <= mem_d;
    end
endmodule

// File: tb/tb_ready_valid_elastic_buf.sv
// tb_ready_valid_elastic_buf: DEPTH=4 and DEPTH=2 buffers on shared stimulus, checked against queue models.
module tb_ready_valid_elastic_buf;
    logic       clk = 1'b0;
    logic       rst, up_valid, down_ready, flush;
    logic [7:0] up_data;
    logic       ur4, dv4, af4, ur2, dv2, af2;
    logic [7:0] dd4, dd2;
    logic [2:0] cnt4;
    logic [1:0] cnt2;
    logic       ur [2], dv [2], af [2];
    logic [7:0] dd [2];
    logic [2:0] cnt [2];
    logic [7:0] sb [2][$];
    int         n_vec = 0, n_fail = 0;
    localparam int DEP [2] = '{4, 2};
    localparam int THR [2] = '{3, 2};

    always #5 clk = ~clk;

    ready_valid_elastic_buf #(.DATA_W(8), .DEPTH(4), .AFULL_THRESH(3)) dut4 (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(ur4),
        .down_data(dd4), .down_valid(dv4), .down_ready(down_ready), .flush(flush),
        .count(cnt4), .almost_full(af4));

    ready_valid_elastic_buf #(.DATA_W(8), .DEPTH(2), .AFULL_THRESH(2)) dut2 (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(ur2),
        .down_data(dd2), .down_valid(dv2), .down_ready(down_ready), .flush(flush),
        .count(cnt2), .almost_full(af2));

    always_comb begin
        ur[0] = ur4; dv[0] = dv4; af[0] = af4; dd[0] = dd4; cnt[0] = cnt4;
        ur[1] = ur2; dv[1] = dv2; af[1] = af2; dd[1] = dd2; cnt[1] = {1'b0, cnt2};
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s depth%0d t=%0t: got %0h expected %0h", nm, DEP[k], $time, act, exp);
        end
    endtask

    // Monitor: compare DUT state against the model, then apply the coming edge's transfers
    always @(negedge clk) begin
        int   sz;
        logic er;
        for (int k = 0; k < 2; k++) begin
            sz = sb[k].size();
            if (rst) begin
                chk("rst_up_ready", k, 32'(ur[k]), 0);
                chk("rst_down_valid", k, 32'(dv[k]), 0);
                chk("rst_down_data", k, 32'(dd[k]), 0);
                chk("rst_almost_full", k, 32'(af[k]), 0);
                sb[k].delete();
            end else begin
                er = !flush && sz < DEP[k];
                chk("up_ready", k, 32'(ur[k]), 32'(er));
                chk("down_valid", k, 32'(dv[k]), 32'(sz != 0));
                chk("count", k, 32'(cnt[k]), 32'(sz));
                chk("almost_full", k, 32'(af[k]), 32'(sz >= THR[k]));
                if (sz != 0) chk("down_data", k, 32'(dd[k]), 32'(sb[k][0]));
                if (flush) sb[k].delete();
                else begin
                    if (sz != 0 && down_ready) void'(sb[k].pop_front());
                    if (up_valid && er) sb[k].push_back(up_data);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        up_valid = 1'b0; down_ready = 1'b1; flush = 1'b0;
        step(6);
    endtask

    initial begin
        rst = 1'b1; up_valid = 1'b0; down_ready = 1'b0; flush = 1'b0; up_data = '0;
        step(2);
        rst = 1'b0; up_valid = 1'b1; down_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            up_data = 8'(i);
            step();
        end
        drain();
        down_ready = 1'b0; up_valid = 1'b1;
        for (int d = 8'h10; d <= 8'h14; d++) begin
            up_data = 8'(d);
            step();
        end
        down_ready = 1'b1;
        step();
        down_ready = 1'b0;
        step();
        drain();
        for (int i = 0; i < 400; i++) begin
            up_valid = i[0]; down_ready = ((i / 3) % 2) == 0; up_data = 8'($urandom);
            step();
        end
        drain();
        up_valid = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            down_ready = ((i / 2) % 2) == 0; up_data = 8'(i);
            step();
        end
        drain();
        down_ready = 1'b0; up_valid = 1'b1;
        for (int d = 8'hA0; d <= 8'hA2; d++) begin
            up_data = 8'(d);
            step();
        end
        up_valid = 1'b0; flush = 1'b1; down_ready = 1'b1;
        step();
        flush = 1'b0; up_valid = 1'b1; up_data = 8'hB0; down_ready = 1'b0;
        step();
        drain();
        down_ready = 1'b0; up_valid = 1'b1;
        up_data = 8'h11; step();
        up_data = 8'h22; step();
        up_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; up_valid = 1'b1; up_data = 8'h55;
        step();
        drain();
        for (int i = 0; i < 3000; i++) begin
            up_valid = $urandom_range(0, 3) != 0;
            down_ready = $urandom_range(0, 2) != 0;
            up_data = 8'($urandom);
            flush = $urandom_range(0, 49) == 0;
            rst = $urandom_range(0, 199) == 0;
            step();
        end
        rst = 1'b0;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
